// File: rtl/uart_pkg.sv
// Shared definitions for the UART: baud-select codes, divisor math, FSM states.
package uart_pkg;

   localparam logic [1:0] BAUD_1200   = 2'b00;
   localparam logic [1:0] BAUD_4800   = 2'b01;
   localparam logic [1:0] BAUD_9600   = 2'b10;
   localparam logic [1:0] BAUD_115200 = 2'b11;

   localparam int FRAME_BITS = 11;
   localparam int DIV_W      = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   function automatic int unsigned baud_rate(logic [1:0] sel);
      int unsigned rate;
      case (sel)
         BAUD_1200: rate = 1200;
         BAUD_4800: rate = 4800;
         BAUD_9600: rate = 9600;
         default:   rate = 115200;
      endcase
      return rate;
   endfunction

   // Bit period in clocks, rounded to nearest; only ever evaluated on constants.
   function automatic logic [DIV_W-1:0] baud_div(int unsigned clk_freq, logic [1:0] sel);
      int unsigned rate;
      rate = baud_rate(sel);
      return DIV_W'((clk_freq + rate / 2) / rate);
   endfunction

   function automatic logic frame_parity(logic [7:0] data, logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on the synchronized line
// ST_START  | counting to the start-bit midpoint, reject glitches there
// ST_DATA   | sampling 8 data bits, LSB first, one per bit period
// ST_PARITY | sampling the parity bit
// ST_STOP   | checking the stop bit; on framing error wait for idle line
module uart_rx_core
   import uart_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_i,
   input  logic [DIV_W-1:0] div_sel_i,
   input  logic             parity_type_i,
   output logic [7:0]       data_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic             parity_error_o
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic             rx_s1_q, rx_s2_q, rx_prev_q;
   logic             fall;
   uart_state_e      state_q;
   logic [DIV_W-1:0] div_q, cnt_q;
   logic [7:0]       shift_q, data_q;
   logic [2:0]       bit_q;
   logic             odd_q, par_q, ferr_q;
   logic             ready_q, busy_q, perr_q;
   logic             tc;

   assign fall = rx_prev_q & ~rx_s2_q;
   assign tc   = (cnt_q == '0);

   // Bring the asynchronous line into the clock domain and keep one delayed copy for edge detect.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Receive FSM; baud and parity type are captured when the start edge is seen.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         bit_q   <= '0;
         odd_q   <= 1'b0;
         par_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  div_q   <= div_sel_i;
                  cnt_q   <= (div_sel_i >> 1) - ONE;
                  odd_q   <= parity_type_i;
                  ferr_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (!tc) begin
                  cnt_q <= cnt_q - ONE;
               end else if (rx_s2_q) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q   <= div_q - ONE;
                  bit_q   <= '0;
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (!tc) begin
                  cnt_q <= cnt_q - ONE;
               end else begin
                  cnt_q   <= div_q - ONE;
                  shift_q <= {rx_s2_q, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (!tc) begin
                  cnt_q <= cnt_q - ONE;
               end else begin
                  cnt_q   <= div_q - ONE;
                  par_q   <= rx_s2_q;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (ferr_q) begin
                  // Framing error: hold here until the line returns high so a
                  // long low period is not mistaken for a new start bit.
                  if (rx_s2_q) begin
                     ferr_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else if (!tc) begin
                  cnt_q <= cnt_q - ONE;
               end else if (rx_s2_q) begin
                  data_q  <= shift_q;
                  perr_q  <= par_q ^ frame_parity(shift_q, odd_q);
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  ferr_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_o         = data_q;
   assign ready_o        = ready_q;
   assign busy_o         = busy_q;
   assign parity_error_o = perr_q;

endmodule

// File: rtl/uart_module.sv
// Full-duplex 8N... 8-data/parity/1-stop UART top: inline transmitter plus RX core.
//
// state     | meaning (TX)
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for send_data
// ST_START  | driving the start bit (0) for one bit period
// ST_DATA   | driving 8 data bits, LSB first
// ST_PARITY | driving (^data) ^ parity_type
// ST_STOP   | driving the stop bit (1); busy drops when it ends
module uart_module
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [1:0] baud_select,
   input  logic [7:0] tx_data_in,
   input  logic       send_data,
   input  logic       parity_type,
   input  logic       rx_in,
   output logic       tx_out,
   output logic       tx_busy,
   output logic [7:0] rx_data_out,
   output logic       rx_data_ready,
   output logic       rx_busy,
   output logic       parity_error
);

   localparam logic [DIV_W-1:0] DIV_1200   = baud_div(CLK_FREQ, BAUD_1200);
   localparam logic [DIV_W-1:0] DIV_4800   = baud_div(CLK_FREQ, BAUD_4800);
   localparam logic [DIV_W-1:0] DIV_9600   = baud_div(CLK_FREQ, BAUD_9600);
   localparam logic [DIV_W-1:0] DIV_115200 = baud_div(CLK_FREQ, BAUD_115200);
   localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

   logic [DIV_W-1:0] div_sel_d;

   uart_state_e      tx_state_q;
   logic [DIV_W-1:0] tx_div_q, tx_cnt_q;
   logic [7:0]       tx_shift_q;
   logic [2:0]       tx_bit_q;
   logic             tx_par_q, tx_out_q, tx_busy_q;
   logic             tx_tc;

   assign tx_tc = (tx_cnt_q == '0);

   // Divisor for the currently selected baud rate; each path latches it at frame start.
   always_comb begin
      div_sel_d = DIV_115200;
      case (baud_select)
         BAUD_1200:   div_sel_d = DIV_1200;
         BAUD_4800:   div_sel_d = DIV_4800;
         BAUD_9600:   div_sel_d = DIV_9600;
         BAUD_115200: div_sel_d = DIV_115200;
         default:     div_sel_d = DIV_115200;
      endcase
   end

   // Transmit FSM; each state holds the line for exactly one latched bit period.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_div_q   <= '0;
         tx_cnt_q   <= '0;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_out_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            ST_IDLE: begin
               if (send_data) begin
                  tx_div_q   <= div_sel_d;
                  tx_cnt_q   <= div_sel_d - ONE;
                  tx_shift_q <= tx_data_in;
                  tx_par_q   <= frame_parity(tx_data_in, parity_type);
                  tx_bit_q   <= '0;
                  tx_out_q   <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  tx_state_q <= ST_START;
               end
            end
            ST_START: begin
               if (!tx_tc) begin
                  tx_cnt_q <= tx_cnt_q - ONE;
               end else begin
                  tx_cnt_q   <= tx_div_q - ONE;
                  tx_out_q   <= tx_shift_q[0];
                  tx_state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (!tx_tc) begin
                  tx_cnt_q <= tx_cnt_q - ONE;
               end else begin
                  tx_cnt_q <= tx_div_q - ONE;
                  if (tx_bit_q == 3'd7) begin
                     tx_out_q   <= tx_par_q;
                     tx_state_q <= ST_PARITY;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_out_q   <= tx_shift_q[1];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (!tx_tc) begin
                  tx_cnt_q <= tx_cnt_q - ONE;
               end else begin
                  tx_cnt_q   <= tx_div_q - ONE;
                  tx_out_q   <= 1'b1;
                  tx_state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (!tx_tc) begin
                  tx_cnt_q <= tx_cnt_q - ONE;
               end else begin
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= ST_IDLE;
               end
            end
            default: begin
               tx_out_q   <= 1'b1;
               tx_busy_q  <= 1'b0;
               tx_state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_out  = tx_out_q;
   assign tx_busy = tx_busy_q;

   uart_rx_core u_rx (
      .clk_i          (sys_clk),
      .rst_i          (reset),
      .rx_i           (rx_in),
      .div_sel_i      (div_sel_d),
      .parity_type_i  (parity_type),
      .data_o         (rx_data_out),
      .ready_o        (rx_data_ready),
      .busy_o         (rx_busy),
      .parity_error_o (parity_error)
   );

endmodule

// File: tb/tb_uart_module.sv
// Self-checking bench for uart_module: loopback and directly driven RX frames
// against a frame-level model, with a reduced clock so frames stay short.
module tb_uart_module;
   import uart_pkg::*;

   localparam int unsigned CLK_TB = 1_152_000;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] baud_select;
   logic [7:0] tx_data_in;
   logic       send_data;
   logic       parity_type;
   logic       loop_en;
   logic       rx_drv;
   logic       rx_line;
   logic       tx_out, tx_busy, rx_data_ready, rx_busy, parity_error;
   logic [7:0] rx_data_out;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] rx_got[$];
   logic       perr_got[$];
   bit         ready_wide = 1'b0;
   logic       ready_prev = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic       last_perr = 1'b0;

   assign rx_line = loop_en ? tx_out : rx_drv;

   always #5 clk = ~clk;

   uart_module #(.CLK_FREQ(CLK_TB)) dut (
      .sys_clk       (clk),
      .reset         (reset),
      .baud_select   (baud_select),
      .tx_data_in    (tx_data_in),
      .send_data     (send_data),
      .parity_type   (parity_type),
      .rx_in         (rx_line),
      .tx_out        (tx_out),
      .tx_busy       (tx_busy),
      .rx_data_out   (rx_data_out),
      .rx_data_ready (rx_data_ready),
      .rx_busy       (rx_busy),
      .parity_error  (parity_error)
   );

   // Capture every received byte and flag any ready pulse longer than one cycle.
   always @(negedge clk) begin
      if (rx_data_ready === 1'b1) begin
         rx_got.push_back(rx_data_out);
         perr_got.push_back(parity_error);
         if (ready_prev === 1'b1) ready_wide = 1'b1;
      end
      ready_prev = rx_data_ready;
   end

   function automatic int model_div(logic [1:0] sel);
      int unsigned rates [4] = '{1200, 4800, 9600, 115200};
      return int'((CLK_TB + rates[sel] / 2) / rates[sel]);
   endfunction

   function automatic logic model_par(logic [7:0] d, logic odd);
      return (^d) ^ odd;
   endfunction

   task automatic drive_rx_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int div);
      logic [10:0] f;
      f = {sbit, pbit, d, 1'b0};
      loop_en = 1'b0;
      for (int b = 0; b < 11; b++) begin
         rx_drv = f[b];
         repeat (div) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      int bad;
      reset = 1'b1; loop_en = 1'b1; rx_drv = 1'b1; send_data = 1'b0;
      baud_select = 2'b10; parity_type = 1'b0; tx_data_in = 8'h00;
      repeat (1000) @(negedge clk);
      tests++;
      if ({tx_out, tx_busy, rx_busy, rx_data_ready, parity_error, rx_data_out} !== 13'b1_0000_0000_0000) begin
         fails++;
         $display("FAIL reset_state: got tx_out=%b tx_busy=%b rx_busy=%b ready=%b perr=%b data=%02h, expected 1 0 0 0 0 00",
                  tx_out, tx_busy, rx_busy, rx_data_ready, parity_error, rx_data_out);
      end
      reset = 1'b0;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || tx_busy !== 1'b0 || rx_busy !== 1'b0 || rx_data_ready !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0 || rx_got.size() != 0) begin
         fails++;
         $display("FAIL idle_after_reset: %0d bad cycles, %0d bytes received, expected 0 and 0", bad, rx_got.size());
      end
   endtask

   task automatic test_divisors;
      int exp_div [4] = '{41667, 10417, 5208, 434};
      int got;
      for (int s = 0; s < 4; s++) begin
         got = int'(baud_div(50_000_000, 2'(s)));
         tests++;
         if (got != exp_div[s]) begin
            fails++;
            $display("FAIL divisor_sel%0d: got %0d expected %0d", s, got, exp_div[s]);
         end
      end
   endtask

   task automatic test_loopback_frame(input logic [7:0] data, input logic [1:0] sel,
                                      input logic pt, input bit perturb);
      int          div, n0, bad, waited;
      logic [10:0] frame;
      bit          seen;
      div   = model_div(sel);
      frame = {1'b1, model_par(data, pt), data, 1'b0};
      loop_en = 1'b1; baud_select = sel; parity_type = pt; tx_data_in = data;
      n0 = rx_got.size();
      send_data = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = (tx_busy === 1'b1);
      end
      send_data = 1'b0;
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL tx_start: tx_busy=%b after 8 cycles, expected 1 (data %02h)", tx_busy, data);
         return;
      end
      for (int b = 0; b < FRAME_BITS; b++) begin
         bad = 0;
         for (int c = 0; c < div; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (perturb && b == 0 && c == div / 2) begin
               baud_select = ~sel; parity_type = ~pt; tx_data_in = ~data;
            end
            if (tx_out !== frame[b] || tx_busy !== 1'b1) bad++;
         end
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL tx_bit%0d: %0d of %0d cycles wrong (data %02h sel %0d), expected tx_out=%b tx_busy=1",
                     b, bad, div, data, sel, frame[b]);
         end
      end
      @(negedge clk);
      tests++;
      if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
         fails++;
         $display("FAIL tx_end: got tx_busy=%b tx_out=%b, expected 0 1", tx_busy, tx_out);
      end
      waited = 0;
      while ((rx_got.size() < n0 + 1 || rx_busy !== 1'b0) && waited < 2 * div + 8) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (rx_got.size() != n0 + 1) begin
         fails++;
         $display("FAIL loop_rx_count: got %0d bytes, expected 1 (data %02h)", rx_got.size() - n0, data);
      end else begin
         tests++;
         if (rx_got[n0] !== data || perr_got[n0] !== 1'b0) begin
            fails++;
            $display("FAIL loop_rx_data: got %02h perr=%b, expected %02h perr=0", rx_got[n0], perr_got[n0], data);
         end
         last_data = data; last_perr = 1'b0;
      end
      tests++;
      if (ready_wide) begin
         fails++;
         ready_wide = 1'b0;
         $display("FAIL ready_width: rx_data_ready high for more than 1 cycle, expected 1-cycle pulse");
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_loopback_fixed;
      test_loopback_frame(8'hAA, 2'b10, 1'b0, 1'b0);
      test_loopback_frame(8'hCC, 2'b10, 1'b1, 1'b0);
   endtask

   task automatic test_loopback_random;
      for (int k = 0; k < 6; k++)
         test_loopback_frame(8'($urandom), 2'($urandom_range(1, 3)), 1'($urandom), 1'b1);
      test_loopback_frame(8'($urandom), 2'b00, 1'($urandom), 1'b1);
   endtask

   task automatic test_back_to_back;
      int         div, n0, waited, gap;
      logic [7:0] d1, d2;
      logic       pt;
      div = model_div(2'b11);
      d1 = 8'($urandom); d2 = 8'($urandom); pt = 1'($urandom);
      loop_en = 1'b1; baud_select = 2'b11; parity_type = pt; tx_data_in = d1;
      n0 = rx_got.size();
      send_data = 1'b1;
      waited = 0;
      while (tx_busy !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
      repeat (3) @(negedge clk);
      tx_data_in = d2;
      waited = 0;
      while (tx_busy === 1'b1 && waited < 11 * div + 4) begin @(negedge clk); waited++; end
      tests++;
      if (waited != 11 * div - 3) begin
         fails++;
         $display("FAIL b2b_busy_len: busy fell after %0d cycles, expected %0d", waited, 11 * div - 3);
      end
      gap = 0;
      while (tx_busy !== 1'b1 && gap < 5) begin @(negedge clk); gap++; end
      send_data = 1'b0;
      tests++;
      if (gap != 1) begin
         fails++;
         $display("FAIL b2b_gap: got %0d idle cycles between frames, expected 1", gap);
      end
      waited = 0;
      while ((rx_got.size() < n0 + 2 || tx_busy === 1'b1 || rx_busy === 1'b1) && waited < 13 * div) begin
         @(negedge clk); waited++;
      end
      tests++;
      if (rx_got.size() != n0 + 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d bytes, expected 2", rx_got.size() - n0);
      end else begin
         tests++;
         if (rx_got[n0] !== d1 || rx_got[n0 + 1] !== d2 || perr_got[n0] !== 1'b0 || perr_got[n0 + 1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_data: got %02h %02h perr %b%b, expected %02h %02h perr 00",
                     rx_got[n0], rx_got[n0 + 1], perr_got[n0], perr_got[n0 + 1], d1, d2);
         end
         last_data = d2; last_perr = 1'b0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_rx_parity;
      int         div, n0;
      logic [7:0] d;
      logic [1:0] sel;
      logic       pt, good, exp_perr;
      loop_en = 1'b0; rx_drv = 1'b1; baud_select = 2'b11; parity_type = 1'b0;
      div = model_div(2'b11);
      repeat (4) @(negedge clk);
      n0 = rx_got.size();
      drive_rx_frame(8'h5A, 1'b1, 1'b1, div);
      tests++;
      if (rx_got.size() != n0 + 1 || rx_data_out !== 8'h5A || parity_error !== 1'b1) begin
         fails++;
         $display("FAIL rx_bad_parity: got %0d bytes data=%02h perr=%b, expected 1 5a 1",
                  rx_got.size() - n0, rx_data_out, parity_error);
      end
      n0 = rx_got.size();
      drive_rx_frame(8'h5A, 1'b0, 1'b1, div);
      tests++;
      if (rx_got.size() != n0 + 1 || rx_data_out !== 8'h5A || parity_error !== 1'b0) begin
         fails++;
         $display("FAIL rx_good_parity: got %0d bytes data=%02h perr=%b, expected 1 5a 0",
                  rx_got.size() - n0, rx_data_out, parity_error);
      end
      for (int k = 0; k < 6; k++) begin
         sel = 2'($urandom_range(1, 3)); pt = 1'($urandom); d = 8'($urandom); good = 1'($urandom);
         baud_select = sel; parity_type = pt;
         exp_perr = ~good;
         n0 = rx_got.size();
         drive_rx_frame(d, model_par(d, pt) ^ exp_perr, 1'b1, model_div(sel));
         tests++;
         if (rx_got.size() != n0 + 1 || rx_data_out !== d || parity_error !== exp_perr) begin
            fails++;
            $display("FAIL rx_random%0d: got %0d bytes data=%02h perr=%b, expected 1 %02h %b",
                     k, rx_got.size() - n0, rx_data_out, parity_error, d, exp_perr);
         end
         last_data = d; last_perr = exp_perr;
      end
   endtask

   task automatic test_rx_glitch_framing;
      int         div, n0, waited;
      bit         seen;
      logic [7:0] d;
      loop_en = 1'b0; rx_drv = 1'b1; baud_select = 2'b10; parity_type = 1'b0;
      div = model_div(2'b10);
      repeat (4) @(negedge clk);
      n0 = rx_got.size();
      rx_drv = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rx_busy === 1'b1) seen = 1'b1;
      end
      rx_drv = 1'b1;
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL glitch_busy: rx_busy never rose during low pulse, expected 1");
      end
      waited = 0;
      while (rx_busy === 1'b1 && waited < div) begin @(negedge clk); waited++; end
      repeat (div) @(negedge clk);
      tests++;
      if (rx_busy !== 1'b0 || rx_got.size() != n0 || rx_data_out !== last_data) begin
         fails++;
         $display("FAIL glitch_reject: rx_busy=%b bytes=%0d data=%02h, expected 0 0 %02h",
                  rx_busy, rx_got.size() - n0, rx_data_out, last_data);
      end
      d = 8'($urandom);
      drive_rx_frame(d, model_par(d, 1'b0), 1'b0, div);
      tests++;
      if (rx_busy !== 1'b0 || rx_got.size() != n0 || rx_data_out !== last_data || parity_error !== last_perr) begin
         fails++;
         $display("FAIL framing_discard: rx_busy=%b bytes=%0d data=%02h perr=%b, expected 0 0 %02h %b",
                  rx_busy, rx_got.size() - n0, rx_data_out, parity_error, last_data, last_perr);
      end
      d = 8'($urandom);
      drive_rx_frame(d, model_par(d, 1'b0), 1'b1, div);
      tests++;
      if (rx_got.size() != n0 + 1 || rx_data_out !== d || parity_error !== 1'b0) begin
         fails++;
         $display("FAIL framing_recover: bytes=%0d data=%02h perr=%b, expected 1 %02h 0",
                  rx_got.size() - n0, rx_data_out, parity_error, d);
      end
      last_data = d; last_perr = 1'b0;
   endtask

   task automatic test_reset_mid;
      int div, waited;
      div = model_div(2'b10);
      loop_en = 1'b1; baud_select = 2'b10; parity_type = 1'b0; tx_data_in = 8'($urandom);
      send_data = 1'b1;
      waited = 0;
      while (tx_busy !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
      send_data = 1'b0;
      repeat (4 * div + div / 2) @(negedge clk);
      tests++;
      if (tx_busy !== 1'b1 || rx_busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_frame_active: tx_busy=%b rx_busy=%b, expected 1 1", tx_busy, rx_busy);
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || rx_busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_frame_reset: tx_out=%b tx_busy=%b rx_busy=%b, expected 1 0 0", tx_out, tx_busy, rx_busy);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      last_data = 8'h00; last_perr = 1'b0;
      tests++;
      if (rx_data_out !== 8'h00 || parity_error !== 1'b0) begin
         fails++;
         $display("FAIL reset_rx_regs: data=%02h perr=%b, expected 00 0", rx_data_out, parity_error);
      end
      repeat (4) @(negedge clk);
      test_loopback_frame(8'h3C, 2'b10, 1'($urandom), 1'b0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_divisors();
      test_loopback_fixed();
      test_loopback_random();
      test_back_to_back();
      test_rx_parity();
      test_rx_glitch_framing();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
